flt2int: RTL
============

# flt2int

Sequential half-precision-float to 16-bit sign-magnitude integer converter; the inverse of the int2flt program. After reset release it reads a float from data memory bytes 5 (high) and 6 (low), converts it through an iterative shifter with round-to-nearest-even, writes the integer to bytes 1 (high) and 2 (low), then raises done. The bench drives it like the int2flt designs: preload memory, hold reset, release, wait for done, read memory.

## Interface
- Parameters:
  - MEM_DEPTH, 256: data memory bytes.
  - FLT_HI, 5: address of the float's high byte.
  - FLT_LO, 6: address of the float's low byte.
  - INT_HI, 1: address of the integer's high byte.
  - INT_LO, 2: address of the integer's low byte.
- Ports (clock and reset first):
  - clk  in  1  single clock; all state changes on its rising edge.
  - reset  in  1  asynchronous, active-high; conversion restarts on release.
  - done  out  1  high once both result bytes are written; stays high until reset.

## Operation
- Float format:
  - bit 15: sign.
  - bits 14:10: exponent e, bias 15.
  - bits 9:0: mantissa m, with hidden one giving M = {1,m} (11 bits).
  - Value is M·2^(e−25).
- Integer format:
  - bit 15: float sign, copied verbatim; -0 gives 0x8000.
  - bits 14:0: magnitude.
- Classification, in state CLASSIFY:
  - e=0: magnitude 0 (denormals flushed), n=0.
  - 1≤e≤13: magnitude 0, n=0.
  - 14≤e≤24: right shift, n=25−e. Guard/sticky are tracked; sticky ORs every bit shifted past guard.
  - e=25: no shift, n=0.
  - 26≤e≤29: left shift, n=e−25; guard/sticky stay 0.
  - e≥30 (includes inf/NaN): magnitude saturates to 0x7FFF, n=0.
- Rounding, in state ROUND: increment the magnitude if guard & (sticky | lsb).
  - The increment cannot exceed 15 bits.
- FSM states and transitions:
  - RD_HI: latch mem[FLT_HI]; next RD_LO.
  - RD_LO: latch mem[FLT_LO]; next CLASSIFY.
  - CLASSIFY: load the shift register and counter n; next SHIFT if n>0, else ROUND.
  - SHIFT: one bit per cycle; decrement n; next ROUND when n reaches 0.
  - ROUND: apply rounding; next WR_HI.
  - WR_HI: write {sign, mag[14:8]} to INT_HI; next WR_LO.
  - WR_LO: write mag[7:0] to INT_LO; next DONE.
  - DONE: hold, done=1.
- Memory behaviour:
  - Combinational read, synchronous write.
  - Write enable is asserted only in WR_HI and WR_LO.
  - Reset does not clear memory contents.

## Timing
- Reset values:
  - done=0.
  - state=RD_HI.
  - All datapath registers 0.
  - Memory write enable 0.
- Latency:
  - Counted from the first rising edge with reset low to the first edge sampling done=1.
  - Equals 7+n cycles; n ranges 0–11, so the worst case is 18.
  - done goes high in the cycle after the WR_LO write.
- Reset mid-operation:
  - Reset is asynchronous: done drops immediately and the FSM returns to RD_HI.
  - Memory bytes already written keep their values; bytes not yet written are unchanged.
  - Conversion restarts from scratch on release.
- Reset asserted in DONE: done drops asynchronously.
- Memory preloaded while reset is high is visible in RD_HI.

## Configuration
- FLT2INT_ROUND_EN:
  - Defined: round-to-nearest-even as described; ties go to even; e=14 yields 1 unless m=0.
  - Undefined: truncate toward zero; guard/sticky logic is removed and ROUND is a pass-through state.
  - Latency is unchanged in both builds.

## Structure
- Package flt2int_pkg:
  - State enum.
  - Constants EXP_BIAS=15, EXP_UNITY=25, EXP_SAT=30, MAG_MAX=15'h7FFF.
  - Address defaults.
- One sub-module, data_mem, instantiated as dm1:
  - Array my_memory[MEM_DEPTH][7:0], directly accessible to the bench hierarchically.
  - Ports: clk, addr, wr_en, data_in, data_out.

## Test plan
- Float 0x3C00 (1.0) → mem[1]=0x00, mem[2]=0x01; done after 17 cycles.
- Float 0x3E00 (1.5) → 0x0002 with ROUND_EN, 0x0001 without. Float 0x3800 (0.5) → 0x0000. Float 0x3A00 (0.75) → 0x0001 with ROUND_EN, 0x0000 without.
- Float 0x77FF (32752) → 0x7FF0 in 11 cycles. Float 0x7BFF → 0x7FFF. Float 0x7C00 → 0x7FFF. Float 0xFC00 → 0xFFFF.
- Float 0xC500 (−5.0) → 0x8005. Float 0x8000 → 0x8000. Float 0x0001 (denormal) → 0x0000.
- Reset asserted during SHIFT for 0x3C00:
  - done stays 0 and mem[1..2] keep their old values.
  - After release, done arrives 17 cycles later with 0x0001.
- Random sweep, 1000 floats: compare against a bench model of the classification/rounding rules and check the 7+n latency on each.

Source files
------------

// File: rtl/flt2int_pkg.sv
// flt2int_pkg: shared FSM state type, exponent constants and default memory map for flt2int.
package flt2int_pkg;
  typedef enum logic [2:0] {RD_HI, RD_LO, CLASSIFY, SHIFT, ROUND, WR_HI, WR_LO, DONE} state_t;
  localparam logic [4:0]  EXP_BIAS  = 5'd15;
  localparam logic [4:0]  EXP_UNITY = 5'd25;
  localparam logic [4:0]  EXP_SAT   = 5'd30;
  localparam logic [14:0] MAG_MAX   = 15'h7FFF;
  localparam int DEF_MEM_DEPTH = 256;
  localparam int DEF_FLT_HI    = 5;
  localparam int DEF_FLT_LO    = 6;
  localparam int DEF_INT_HI    = 1;
  localparam int DEF_INT_LO    = 2;
endpackage

// File: rtl/flt2int_data_mem.sv
// data_mem: byte memory with combinational read and synchronous write; contents survive reset.
module data_mem #(
  parameter int MEM_DEPTH = 256
) (
  input  logic                         clk,
  input  logic [$clog2(MEM_DEPTH)-1:0] addr,
  input  logic                         wr_en,
  input  logic [7:0]                   data_in,
  output logic [7:0]                   data_out
);
  logic [7:0] my_memory [MEM_DEPTH];
  always_ff @(posedge clk)
    if (wr_en) my_memory[addr] <= data_in;
  assign data_out = my_memory[addr];
endmodule

// File: rtl/flt2int.sv
// flt2int: half-float to sign-magnitude int16 via an iterative shifter; FLT2INT_ROUND_EN selects round-to-nearest-even, else truncation.
module flt2int
  import flt2int_pkg::*;
#(
  parameter int MEM_DEPTH = DEF_MEM_DEPTH,
  parameter int FLT_HI    = DEF_FLT_HI,
  parameter int FLT_LO    = DEF_FLT_LO,
  parameter int INT_HI    = DEF_INT_HI,
  parameter int INT_LO    = DEF_INT_LO
) (
  input  logic clk,
  input  logic reset,
  output logic done
);
  localparam int AW = $clog2(MEM_DEPTH);
  state_t      r_state;
  logic [15:0] r_flt;
  logic [14:0] r_mag;
  logic [3:0]  r_n;
  logic        r_left;
  logic [4:0]  w_exp;
  logic [10:0] w_man;
  logic [3:0]  w_n;
  logic [AW-1:0] w_addr;
  logic        w_wr_en, w_rnd;
  logic [7:0]  w_din, w_dout;
  assign w_exp   = r_flt[14:10];
  assign w_man   = {1'b1, r_flt[9:0]};
  assign w_n     = 4'((w_exp < EXP_BIAS - 5'd1 || w_exp >= EXP_SAT) ? 5'd0 :
                      (w_exp <= EXP_UNITY) ? EXP_UNITY - w_exp : w_exp - EXP_UNITY);
  assign w_addr  = AW'(r_state == RD_HI ? FLT_HI : r_state == RD_LO ? FLT_LO :
                       r_state == WR_HI ? INT_HI : INT_LO);
  assign w_wr_en = (r_state == WR_HI) || (r_state == WR_LO);
  assign w_din   = (r_state == WR_HI) ? {r_flt[15], r_mag[14:8]} : r_mag[7:0];
`ifdef FLT2INT_ROUND_EN
  logic r_guard, r_sticky;
  assign w_rnd = r_guard & (r_sticky | r_mag[0]);
`else
  assign w_rnd = 1'b0;
`endif
  data_mem #(.MEM_DEPTH(MEM_DEPTH)) dm1 (
    .clk(clk), .addr(w_addr), .wr_en(w_wr_en), .data_in(w_din), .data_out(w_dout)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RD_HI;
      r_flt   <= '0;
      r_mag   <= '0;
      r_n     <= '0;
      r_left  <= 1'b0;
      done    <= 1'b0;
`ifdef FLT2INT_ROUND_EN
      r_guard  <= 1'b0;
      r_sticky <= 1'b0;
`endif
    end else begin
      case (r_state)
        RD_HI: begin
          r_flt[15:8] <= w_dout;
          r_state     <= RD_LO;
        end
        RD_LO: begin
          r_flt[7:0] <= w_dout;
          r_state    <= CLASSIFY;
        end
        CLASSIFY: begin
          r_mag   <= (w_exp < EXP_BIAS - 5'd1) ? 15'd0 : (w_exp >= EXP_SAT) ? MAG_MAX : {4'b0, w_man};
          r_left  <= w_exp > EXP_UNITY;
          r_n     <= w_n;
          r_state <= (w_n != 4'd0) ? SHIFT : ROUND;
`ifdef FLT2INT_ROUND_EN
          r_guard  <= 1'b0;
          r_sticky <= 1'b0;
`endif
        end
        SHIFT: begin
          r_mag   <= r_left ? r_mag << 1 : r_mag >> 1;
          r_n     <= r_n - 4'd1;
          r_state <= (r_n == 4'd1) ? ROUND : SHIFT;
`ifdef FLT2INT_ROUND_EN
          // sticky collects every bit that falls past the guard position
          if (!r_left) begin
            r_guard  <= r_mag[0];
            r_sticky <= r_sticky | r_guard;
          end
`endif
        end
        ROUND: begin
          r_mag   <= r_mag + {14'd0, w_rnd};
          r_state <= WR_HI;
        end
        WR_HI: r_state <= WR_LO;
        WR_LO: begin
          r_state <= DONE;
          done    <= 1'b1;
        end
        DONE: r_state <= DONE;
        default: r_state <= RD_HI;
      endcase
    end
  end
endmodule
